// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the MIPS-subset CPU.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// state-dependent strobes, PC/writeback muxes and the memory handshake.
// The external combinational decoder still supplies the ALU controls.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  dest_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       retired_q, retired_d;
  logic              retire;

  // Instruction class decode; only what changes sequencing or strobes.
  logic [5:0] opcode, funct;
  logic       is_rtype, is_jr, is_j, is_jal, is_branch, is_lw, is_sw, legal;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  assign is_rtype  = (opcode == 6'h00);
  assign is_jr     = is_rtype && (funct == 6'h08);
  assign is_j      = (opcode == 6'h02);
  assign is_jal    = (opcode == 6'h03);
  assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);
  assign is_lw     = (opcode == 6'h23);
  assign is_sw     = (opcode == 6'h2B);

  // Legal opcode/funct table.
  always_comb begin
    legal = 1'b0;
    if (is_rtype) begin
      case (funct)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B: legal = 1'b1;
        default:      legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h02, 6'h03, 6'h04, 6'h05,
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
        6'h23, 6'h2B: legal = 1'b1;
        default:      legal = 1'b0;
      endcase
    end
  end

  // A request times out when the final permitted wait cycle sees no ready.
  logic timeout;
  assign timeout = !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state, wait counter, retire pulse and all strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 2'b00;
    dest_sel   = 2'b00;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = enable;
        if (!enable) begin
          wait_d = '0;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          rf_we    = is_jal;
          wb_sel   = is_jal ? 2'b10 : 2'b00;
          dest_sel = is_jal ? 2'b10 : 2'b00;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_write = branch_taken;
          pc_src   = 2'b01;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (mem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = is_lw ? 2'b01 : 2'b00;
        dest_sel = is_rtype ? 2'b01 : 2'b00;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Every fresh request starts counting from zero.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_d = '0;

    state      = state_q;
    trap_cause = cause_q;
    retired    = retired_q;

    // Outputs are forced quiet for as long as reset is held.
    if (!rst_n) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = 2'b00;
      dest_sel   = 2'b00;
      trap       = 1'b0;
      state      = 3'd0;
      trap_cause = 2'b00;
      retired    = 32'd0;
    end
  end

  assign retired_d = retired_q + {31'd0, retire};

  // State, wait counter, trap cause and retirement counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

endmodule
